keypad_encoder: RTL

- Upstream stage of the cooking timer. Turns a 10-key decimal keypad into single-digit BCD load strobes.
- Each clean key press produces exactly one `data`/`loadn` transaction, which the timer shifts in as the next digit.
- Handles input synchronisation, debounce, rejection of invalid chords and release detection.

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_sync.sv | 26 ++
 rtl/keypad_encoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad encoder: key count, BCD width,
// FSM state enum and the one-hot to BCD decoder.
package keypad_pkg;

  localparam int unsigned NUM_KEYS = 10;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] code;
  } key_dec_t;

  // Exactly one line set gives a valid digit; none or a chord gives valid=0.
  function automatic key_dec_t onehot_to_bcd(input logic [NUM_KEYS-1:0] keys);
    key_dec_t    res;
    int unsigned ones;
    res.valid = 1'b0;
    res.code  = '0;
    ones      = 0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) begin
        ones     = ones + 1;
        res.code = CODE_W'(i);
      end
    end
    res.valid = (ones == 1);
    if (!res.valid) begin
      res.code = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous key lines, with synchronous clear.
module keypad_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// Decimal keypad to BCD load-strobe encoder with debounce and release detection.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 50
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                enable,
  output logic [CODE_W-1:0]   data,
  output logic                loadn,
  output logic                pressed
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("keypad_encoder: parameter out of range");
  end

  logic [NUM_KEYS-1:0] sync_key;
  key_dec_t            dec;
  logic                key_none;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;
  logic                loadn_q, loadn_d;
  logic                pressed_q, pressed_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  keypad_sync #(
    .WIDTH (NUM_KEYS)
  ) u_sync (
    .clock   (clock),
    .clear   (clear),
    .async_i (keypad),
    .sync_o  (sync_key)
  );

  assign dec      = onehot_to_bcd(sync_key);
  assign key_none = ~|sync_key;

  // Next-state and output decision; loadn defaults high so it pulses for one cycle.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    loadn_d   = 1'b1;
    pressed_d = pressed_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = rep_q;
`endif

    case (state_q)
      IDLE: begin
        if (dec.valid && enable) begin
          code_d  = dec.code;
          cnt_d   = CNT_W'(1);
          state_d = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (dec.valid && enable && (dec.code == code_q)) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
            data_d    = code_q;
            loadn_d   = 1'b0;
            pressed_d = 1'b1;
            cnt_d     = '0;
            rcnt_d    = '0;
            state_d   = HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_d     = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      HELD: begin
        if (key_none) begin
`ifdef KEYPAD_REPEAT_EN
          rep_d = '0;
`endif
          if (rcnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            rcnt_d    = '0;
            pressed_d = 1'b0;
            state_d   = IDLE;
          end else begin
            rcnt_d = rcnt_q + CNT_W'(1);
          end
        end else begin
          // Any key activity, including chords, restarts the release count.
          rcnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
          if (dec.valid && (dec.code == data_q)) begin
            if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
              loadn_d = 1'b0;
              rep_d   = '0;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end else begin
            rep_d = '0;
          end
`endif
        end
      end

      default: begin
        cnt_d     = '0;
        rcnt_d    = '0;
        pressed_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      code_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      loadn_q   <= 1'b1;
      pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      loadn_q   <= loadn_d;
      pressed_q <= pressed_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign data    = data_q;
  assign loadn   = loadn_q;
  assign pressed = pressed_q;

endmodule
